// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: opcode constants, the
// hazard controller state type and the source-register usage decode.
package mips_pkg;

    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] J     = 6'h02;
    localparam logic [5:0] JAL   = 6'h03;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] BNE   = 6'h05;
    localparam logic [5:0] ADDIU = 6'h09;
    localparam logic [5:0] SLTI  = 6'h0A;
    localparam logic [5:0] ANDI  = 6'h0C;
    localparam logic [5:0] ORI   = 6'h0D;
    localparam logic [5:0] XORI  = 6'h0E;
    localparam logic [5:0] LUI   = 6'h0F;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    // Jumps carry a target instead of rs, and LUI has only an immediate.
    function automatic logic usesRs(input logic [5:0] op);
        return !((op == J) || (op == JAL) || (op == LUI));
    endfunction

    // Only R-type, the compare branches and stores actually read rt;
    // for I-type ALU ops and loads rt is a destination.
    function automatic logic usesRt(input logic [5:0] op);
        return (op == RTYPE) || (op == BEQ) || (op == BNE) || (op == SW);
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Advance by one on each event unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, branch/jump squashes,
// data-memory waits, saturating perf counters and a sticky timeout flag.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_jump,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_stall,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int              TMR_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MEM_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    hz_state_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timeout_q, timeout_d;
    logic             memWait;
    logic             loadUse;

    assign loadUse = ex_memread && (ex_rt != 5'd0) &&
                     ((usesRs(id_opcode) && (ex_rt == id_rs)) ||
                      (usesRt(id_opcode) && (ex_rt == id_rt)));

    // Wait FSM next state, consecutive-wait timer and sticky timeout flag.
    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        timeout_d = timeout_q;
        memWait   = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    memWait = 1'b1;
                    state_d = MEM_WAIT;
                    timer_d = TMR_ONE;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    memWait = 1'b1;
                    timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_ONE;
                end
            end
            default: state_d = RUN;
        endcase
        if (timer_d == TMR_MAX) begin
            timeout_d = 1'b1;
        end
    end

    // Pipeline controls by priority: reset, memory wait, taken branch,
    // load-use, jump, then normal flow.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        bubble     = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        mem_stall  = 1'b0;
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
        end else if (memWait) begin
            mem_stall  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (loadUse) begin
            bubble     = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    // State, timer and flag registers; reset discards any in-flight wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (!pc_write),
        .count_o (stall_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (ifid_flush),
        .count_o (flush_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a default-parameter instance and a
// small one (4-bit counters, timeout of 4) share the same stimulus.
module tb_hazard_unit;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] idOpcode;
    logic [4:0] idRs, idRt, exRt;
    logic       idJump, exMemread, exBranchTaken, memReq, memReady;

    logic        pcWriteA, ifidWriteA, bubbleA, ifidFlushA, idexFlushA, memStallA, memTimeoutA;
    logic [31:0] stallCountA, flushCountA;
    logic        pcWriteB, ifidWriteB, bubbleB, ifidFlushB, idexFlushB, memStallB, memTimeoutB;
    logic [3:0]  stallCountB, flushCountB;

    int checkCount = 0;
    int errorCount = 0;

    hazard_unit dut (
        .clk(clk), .reset(reset), .id_opcode(idOpcode), .id_rs(idRs), .id_rt(idRt),
        .id_jump(idJump), .ex_memread(exMemread), .ex_rt(exRt),
        .ex_branch_taken(exBranchTaken), .mem_req(memReq), .mem_ready(memReady),
        .pc_write(pcWriteA), .ifid_write(ifidWriteA), .bubble(bubbleA),
        .ifid_flush(ifidFlushA), .idex_flush(idexFlushA), .mem_stall(memStallA),
        .mem_timeout(memTimeoutA), .stall_count(stallCountA), .flush_count(flushCountA)
    );

    hazard_unit #(.CNT_W(4), .MEM_TIMEOUT(4)) dutSmall (
        .clk(clk), .reset(reset), .id_opcode(idOpcode), .id_rs(idRs), .id_rt(idRt),
        .id_jump(idJump), .ex_memread(exMemread), .ex_rt(exRt),
        .ex_branch_taken(exBranchTaken), .mem_req(memReq), .mem_ready(memReady),
        .pc_write(pcWriteB), .ifid_write(ifidWriteB), .bubble(bubbleB),
        .ifid_flush(ifidFlushB), .idex_flush(idexFlushB), .mem_stall(memStallB),
        .mem_timeout(memTimeoutB), .stall_count(stallCountB), .flush_count(flushCountB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then let logic settle.
    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic jump,
                                 input logic memread, input logic [4:0] xRt,
                                 input logic brTaken, input logic req,
                                 input logic ready);
        @(negedge clk);
        idOpcode      = op;
        idRs          = rs;
        idRt          = rt;
        idJump        = jump;
        exMemread     = memread;
        exRt          = xRt;
        exBranchTaken = brTaken;
        memReq        = req;
        memReady      = ready;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(RTYPE, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        idOpcode = RTYPE; idRs = '0; idRt = '0; idJump = 1'b0; exMemread = 1'b0;
        exRt = '0; exBranchTaken = 1'b0; memReq = 1'b0; memReady = 1'b0;

        // Reset values
        @(negedge clk); #1;
        checkOutput("rst pc_write", pcWriteA, 0);
        checkOutput("rst ifid_write", ifidWriteA, 0);
        checkOutput("rst bubble", bubbleA, 1);
        checkOutput("rst mem_stall", memStallA, 0);
        checkOutput("rst stall_count", stallCountA, 0);
        checkOutput("rst mem_timeout", memTimeoutA, 0);
        reset = 1'b0;

        applyIdle();
        checkOutput("idle pc_write", pcWriteA, 1);
        checkOutput("idle bubble", bubbleA, 0);

        // Load-use on rs of an R-type
        applyStimulus(RTYPE, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        checkOutput("lu bubble", bubbleA, 1);
        checkOutput("lu pc_write", pcWriteA, 0);
        checkOutput("lu ifid_write", ifidWriteA, 0);
        checkOutput("lu stall_count before", stallCountA, 0);
        applyIdle();
        checkOutput("post-lu pc_write", pcWriteA, 1);
        checkOutput("lu stall_count after", stallCountA, 1);

        // Register 0 and non-reading opcodes never stall
        applyStimulus(RTYPE, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("r0 bubble", bubbleA, 0);
        checkOutput("r0 pc_write", pcWriteA, 1);
        applyStimulus(LUI, 5'd8, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        checkOutput("lui bubble", bubbleA, 0);
        applyStimulus(SW, 5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        checkOutput("sw rt bubble", bubbleA, 1);
        applyStimulus(ADDIU, 5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        checkOutput("addiu rt bubble", bubbleA, 0);
        checkOutput("stall_count 2", stallCountA, 2);

        // Jump squashes IF/ID only; J does not read rs
        applyStimulus(J, 5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        checkOutput("jump bubble", bubbleA, 0);
        checkOutput("jump ifid_flush", ifidFlushA, 1);
        checkOutput("jump idex_flush", idexFlushA, 0);
        checkOutput("jump pc_write", pcWriteA, 1);
        applyIdle();
        checkOutput("flush_count 1", flushCountA, 1);

        // Taken branch overrides load-use
        applyStimulus(RTYPE, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        checkOutput("br ifid_flush", ifidFlushA, 1);
        checkOutput("br idex_flush", idexFlushA, 1);
        checkOutput("br bubble", bubbleA, 0);
        checkOutput("br pc_write", pcWriteA, 1);

        // Load-use overrides jump
        applyStimulus(RTYPE, 5'd0, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        checkOutput("lu+j bubble", bubbleA, 1);
        checkOutput("lu+j ifid_flush", ifidFlushA, 0);
        checkOutput("lu+j pc_write", pcWriteA, 0);
        checkOutput("flush_count 2", flushCountA, 2);

        // Three memory-wait cycles, then ready together with a taken branch
        applyStimulus(RTYPE, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("mw1 mem_stall", memStallA, 1);
        checkOutput("mw1 pc_write", pcWriteA, 0);
        checkOutput("mw1 ifid_write", ifidWriteA, 0);
        checkOutput("mw1 stall_count", stallCountA, 3);
        applyStimulus(RTYPE, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("mw2 mem_stall", memStallA, 1);
        checkOutput("mw2 ifid_flush", ifidFlushA, 0);
        checkOutput("mw2 idex_flush", idexFlushA, 0);
        applyStimulus(RTYPE, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("mw3 mem_stall", memStallA, 1);
        applyStimulus(RTYPE, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        checkOutput("rdy mem_stall", memStallA, 0);
        checkOutput("rdy ifid_flush", ifidFlushA, 1);
        checkOutput("rdy pc_write", pcWriteA, 1);
        checkOutput("stall_count 6", stallCountA, 6);
        checkOutput("small timeout below limit", memTimeoutB, 0);
        applyIdle();
        checkOutput("back in RUN mem_stall", memStallA, 0);
        checkOutput("flush_count 3", flushCountA, 3);
        checkOutput("default mem_timeout", memTimeoutA, 0);

        // Timeout on the small instance: sets after the 4th wait edge
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(RTYPE, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("to%0d mem_stall", i), memStallB, 1);
            checkOutput($sformatf("to%0d mem_timeout", i), memTimeoutB, (i >= 5) ? 1 : 0);
        end

        // Reset mid-wait
        @(negedge clk); reset = 1'b1; #1;
        checkOutput("midrst mem_timeout", memTimeoutB, 0);
        checkOutput("midrst mem_stall", memStallB, 0);
        checkOutput("midrst bubble", bubbleB, 1);
        checkOutput("midrst stall_count", stallCountB, 0);
        checkOutput("midrst flush_count", flushCountB, 0);
        applyIdle();
        reset = 1'b0; #1;
        checkOutput("postrst mem_stall", memStallB, 0);
        checkOutput("postrst pc_write", pcWriteB, 1);

        // 20 held load-use cycles: 4-bit counter saturates at 15
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(RTYPE, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("sat%0d stall_count", k), stallCountB,
                        (k - 1 > 15) ? 15 : k - 1);
        end
        applyIdle();
        checkOutput("sat final stall_count", stallCountB, 15);
        checkOutput("wide stall_count 20", stallCountA, 20);
        checkOutput("small timeout after reset", memTimeoutB, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
